// File: rtl/pixel_depth_compositor.sv
// -----------------------------------------------------------------------------
// pixel_depth_compositor
//
// Resolves up to NUM_CH overlapping fragment channels into one RGB pixel per
// clock. The channels are reduced by a registered binary tree, either by fixed
// priority (lowest index wins) or by nearest signed depth. The pixel's timing
// signals, resolve mode and background colour travel down the tree alongside
// it. A per-frame counter reports how many displayed pixels had two or more
// covering fragments.
//
// Ports
//   clk_pix, rst_pix        pixel clock, synchronous active-high reset
//   frame_start             one-cycle pulse at the start of each frame
//   in_hsync/in_vsync/in_de display timing for the incoming pixel
//   frag_inside             per-channel coverage flags (bit i = channel i)
//   frag_z                  per-channel signed depth, channel i at [i*Z_W +: Z_W]
//   frag_color              per-channel colour, channel i at [i*COLOR_W +: COLOR_W]
//   cfg_mode                0 = priority, 1 = nearest depth (shadowed on frame_start)
//   cfg_bg_color            background colour (shadowed on frame_start)
//   vga_hsync/vga_vsync     timing delayed by LAT cycles
//   vga_r/vga_g/vga_b       resolved colour, r = MSB third, b = LSB third
//   stat_overlap            overlap-pixel count of the previous frame
//   stat_valid              one-cycle pulse when stat_overlap updates
// -----------------------------------------------------------------------------
module pixel_depth_compositor #(
  parameter int NUM_CH  = 4,
  parameter int Z_W     = 32,
  parameter int COLOR_W = 12,
  parameter int STAT_W  = 20
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix,
  input  logic                      frame_start,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
  input  logic                      in_de,
  input  logic [NUM_CH-1:0]         frag_inside,
  input  logic [NUM_CH*Z_W-1:0]     frag_z,
  input  logic [NUM_CH*COLOR_W-1:0] frag_color,
  input  logic                      cfg_mode,
  input  logic [COLOR_W-1:0]        cfg_bg_color,
  output logic                      vga_hsync,
  output logic                      vga_vsync,
  output logic [COLOR_W/3-1:0]      vga_r,
  output logic [COLOR_W/3-1:0]      vga_g,
  output logic [COLOR_W/3-1:0]      vga_b,
  output logic [STAT_W-1:0]         stat_overlap,
  output logic                      stat_valid
);

  localparam int LVL = $clog2(NUM_CH);
  localparam int P   = 1 << LVL;
  localparam int C3  = COLOR_W / 3;
  localparam logic [COLOR_W-1:0] BG_RST = COLOR_W'(8);

  // ---------------------------------------------------------------------------
  // Configuration shadow registers
  // ---------------------------------------------------------------------------
  logic               act_mode_q;
  logic [COLOR_W-1:0] act_bg_q;
  logic               pix_mode;
  logic [COLOR_W-1:0] pix_bg;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      act_mode_q <= 1'b0;
      act_bg_q   <= BG_RST;
    end else if (frame_start) begin
      act_mode_q <= cfg_mode;
      act_bg_q   <= cfg_bg_color;
    end
  end

  // The pixel presented together with frame_start already uses the new values.
  assign pix_mode = frame_start ? cfg_mode : act_mode_q;
  assign pix_bg   = frame_start ? cfg_bg_color : act_bg_q;

  // ---------------------------------------------------------------------------
  // Reduction tree
  // ---------------------------------------------------------------------------
  // Higher-index input b replaces a only if it is inside and either a is not,
  // or depth mode is active and b is strictly nearer. Ties keep the lower index.
  function automatic logic b_wins(input logic                  a_in,
                                  input logic signed [Z_W-1:0] a_z,
                                  input logic                  b_in,
                                  input logic signed [Z_W-1:0] b_z,
                                  input logic                  mode);
    return b_in && (!a_in || (mode && (b_z < a_z)));
  endfunction

  // Level 0 is the masked input; levels 1..LVL are registered tree stages.
  for (genvar lv = 0; lv <= LVL; lv++) begin : g_lvl
    localparam int N = P >> lv;

    logic                      ins [N];
    logic signed [Z_W-1:0]     z   [N];
    logic        [COLOR_W-1:0] col [N];
    logic                      mode;
    logic                      de;
    logic                      hs;
    logic                      vs;
    logic        [COLOR_W-1:0] bg;

    if (lv == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_ch
        if (i < NUM_CH) begin : g_real
          // Non-covering channels are zeroed so their depth/colour cannot leak.
          assign ins[i] = frag_inside[i];
          assign z[i]   = frag_inside[i] ? frag_z[i*Z_W +: Z_W] : '0;
          assign col[i] = frag_inside[i] ? frag_color[i*COLOR_W +: COLOR_W] : '0;
        end else begin : g_pad
          assign ins[i] = 1'b0;
          assign z[i]   = '0;
          assign col[i] = '0;
        end
      end
      assign mode = pix_mode;
      assign de   = in_de;
      assign hs   = in_hsync;
      assign vs   = in_vsync;
      assign bg   = pix_bg;
    end else begin : g_node
      always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
          for (int n = 0; n < N; n++) begin
            ins[n] <= 1'b0;
            z[n]   <= '0;
            col[n] <= '0;
          end
          mode <= 1'b0;
          de   <= 1'b0;
          hs   <= 1'b0;
          vs   <= 1'b0;
          bg   <= '0;
        end else begin
          for (int n = 0; n < N; n++) begin
            if (b_wins(g_lvl[lv-1].ins[2*n],   g_lvl[lv-1].z[2*n],
                       g_lvl[lv-1].ins[2*n+1], g_lvl[lv-1].z[2*n+1],
                       g_lvl[lv-1].mode)) begin
              ins[n] <= g_lvl[lv-1].ins[2*n+1];
              z[n]   <= g_lvl[lv-1].z[2*n+1];
              col[n] <= g_lvl[lv-1].col[2*n+1];
            end else begin
              ins[n] <= g_lvl[lv-1].ins[2*n];
              z[n]   <= g_lvl[lv-1].z[2*n];
              col[n] <= g_lvl[lv-1].col[2*n];
            end
          end
          mode <= g_lvl[lv-1].mode;
          de   <= g_lvl[lv-1].de;
          hs   <= g_lvl[lv-1].hs;
          vs   <= g_lvl[lv-1].vs;
          bg   <= g_lvl[lv-1].bg;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] out_color_d;
  logic [COLOR_W-1:0] out_color_q;
  logic               out_hs_q;
  logic               out_vs_q;

  always_comb begin
    out_color_d = '0;
    if (g_lvl[LVL].de) begin
      out_color_d = g_lvl[LVL].ins[0] ? g_lvl[LVL].col[0] : g_lvl[LVL].bg;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      out_color_q <= '0;
      out_hs_q    <= 1'b0;
      out_vs_q    <= 1'b0;
    end else begin
      out_color_q <= out_color_d;
      out_hs_q    <= g_lvl[LVL].hs;
      out_vs_q    <= g_lvl[LVL].vs;
    end
  end

  assign vga_hsync = out_hs_q;
  assign vga_vsync = out_vs_q;
  assign vga_r     = out_color_q[COLOR_W-1 -: C3];
  assign vga_g     = out_color_q[C3 +: C3];
  assign vga_b     = out_color_q[0 +: C3];

  // ---------------------------------------------------------------------------
  // Overlap statistics
  // ---------------------------------------------------------------------------
  logic              overlap_now;
  logic [STAT_W-1:0] cnt_d;
  logic [STAT_W-1:0] cnt_q;
  logic [STAT_W-1:0] stat_overlap_q;
  logic              stat_valid_q;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign overlap_now = in_de && ((frag_inside & (frag_inside - NUM_CH'(1))) != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (frame_start) begin
      cnt_d = overlap_now ? STAT_W'(1) : '0;
    end else if (overlap_now && (cnt_q != {STAT_W{1'b1}})) begin
      cnt_d = cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cnt_q          <= '0;
      stat_overlap_q <= '0;
      stat_valid_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stat_valid_q <= frame_start;
      if (frame_start) begin
        stat_overlap_q <= cnt_q;
      end
    end
  end

  assign stat_overlap = stat_overlap_q;
  assign stat_valid   = stat_valid_q;

endmodule

// File: tb/tb_pixel_depth_compositor.sv
module tb_pixel_depth_compositor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fs, hs, vs, de, mode;
  logic [11:0] bg;
  logic [3:0]   ins4;
  logic [127:0] z4;
  logic [47:0]  col4;
  logic [2:0]   ins3;
  logic [95:0]  z3;
  logic [35:0]  col3;
  logic         ins1;
  logic [31:0]  z1;
  logic [11:0]  col1;

  logic        hs4, vs4, sv4, hs3, vs3, sv3, hs1, vs1, sv1, hsS, vsS, svS;
  logic [3:0]  r4, g4, b4, r3, g3, b3, r1, g1, b1, rS, gS, bS;
  logic [19:0] so4, so3, so1;
  logic [2:0]  soS;
  logic [11:0] rgb4, rgb3, rgb1;

  assign rgb4 = {r4, g4, b4};
  assign rgb3 = {r3, g3, b3};
  assign rgb1 = {r1, g1, b1};

  pixel_depth_compositor u_dut4 (
    .clk_pix(clk), .rst_pix(rst), .frame_start(fs),
    .in_hsync(hs), .in_vsync(vs), .in_de(de),
    .frag_inside(ins4), .frag_z(z4), .frag_color(col4),
    .cfg_mode(mode), .cfg_bg_color(bg),
    .vga_hsync(hs4), .vga_vsync(vs4), .vga_r(r4), .vga_g(g4), .vga_b(b4),
    .stat_overlap(so4), .stat_valid(sv4));

  pixel_depth_compositor #(.NUM_CH(3)) u_dut3 (
    .clk_pix(clk), .rst_pix(rst), .frame_start(fs),
    .in_hsync(hs), .in_vsync(vs), .in_de(de),
    .frag_inside(ins3), .frag_z(z3), .frag_color(col3),
    .cfg_mode(mode), .cfg_bg_color(bg),
    .vga_hsync(hs3), .vga_vsync(vs3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .stat_overlap(so3), .stat_valid(sv3));

  pixel_depth_compositor #(.NUM_CH(1)) u_dut1 (
    .clk_pix(clk), .rst_pix(rst), .frame_start(fs),
    .in_hsync(hs), .in_vsync(vs), .in_de(de),
    .frag_inside(ins1), .frag_z(z1), .frag_color(col1),
    .cfg_mode(mode), .cfg_bg_color(bg),
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .stat_overlap(so1), .stat_valid(sv1));

  pixel_depth_compositor #(.STAT_W(3)) u_sat (
    .clk_pix(clk), .rst_pix(rst), .frame_start(fs),
    .in_hsync(hs), .in_vsync(vs), .in_de(de),
    .frag_inside(ins4), .frag_z(z4), .frag_color(col4),
    .cfg_mode(mode), .cfg_bg_color(bg),
    .vga_hsync(hsS), .vga_vsync(vsS), .vga_r(rS), .vga_g(gS), .vga_b(bS),
    .stat_overlap(soS), .stat_valid(svS));

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] rgb1_cap, rgb4_early;
  logic [7:0]  h_pat, v_pat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    fs = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    ins4 = '0; z4 = '0; col4 = '0;
    ins3 = '0; z3 = '0; col3 = '0;
    ins1 = 1'b0; z1 = '0; col1 = '0;
  endtask

  task automatic set4(input int i, input logic [31:0] zv, input logic [11:0] cv, input logic iv);
    z4[i*32 +: 32]   = zv;
    col4[i*12 +: 12] = cv;
    ins4[i]          = iv;
  endtask

  // ch1 (za, F00) and ch3 (zb, 0F0) covering; ch0/ch2 carry junk but are not inside.
  task automatic stim(input logic [31:0] za, input logic [31:0] zb);
    clear_in();
    de = 1'b1;
    set4(0, 32'hFFFF_FF9C, 12'h00F, 1'b0);
    set4(1, za,            12'hF00, 1'b1);
    set4(2, 32'hFFFF_FF38, 12'hFFF, 1'b0);
    set4(3, zb,            12'h0F0, 1'b1);
    ins3 = 3'b110;
    z3   = {zb, za, 32'hFFFF_FF9C};
    col3 = {12'h0F0, 12'hF00, 12'h00F};
    ins1 = 1'b1;
    z1   = za;
    col1 = 12'hF00;
  endtask

  // Present the current inputs for one cycle, then idle; leaves the 3-cycle
  // result on the outputs and captures the 1-cycle DUT and an early sample.
  task automatic run_pixel();
    step();
    rgb1_cap = rgb1;
    clear_in();
    step();
    rgb4_early = rgb4;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; bg = 12'h000;
    clear_in();
    repeat (3) step();
    check_eq("rst_rgb4", {20'd0, rgb4}, 32'h0);
    check_eq("rst_sync4", {30'd0, hs4, vs4}, 32'h0);
    check_eq("rst_stat4", {11'd0, sv4, so4}, 32'h0);
    check_eq("rst_rgb3", {20'd0, rgb3}, 32'h0);
    check_eq("rst_rgb1", {20'd0, rgb1}, 32'h0);

    rst = 1'b0;
    clear_in(); de = 1'b1;
    run_pixel();
    check_eq("bg_reset4", {20'd0, rgb4}, 32'h008);
    check_eq("bg_reset1", {20'd0, rgb1_cap}, 32'h008);

    stim(32'd50, 32'd10); fs = 1'b1; mode = 1'b0; bg = 12'h0A5;
    run_pixel();
    check_eq("prio4", {20'd0, rgb4}, 32'hF00);
    check_eq("prio4_early", {20'd0, rgb4_early}, 32'h0);
    check_eq("prio3", {20'd0, rgb3}, 32'hF00);
    check_eq("prio1", {20'd0, rgb1_cap}, 32'hF00);

    stim(32'd50, 32'd10); fs = 1'b1; mode = 1'b1;
    run_pixel();
    check_eq("depth4", {20'd0, rgb4}, 32'h0F0);
    check_eq("depth3", {20'd0, rgb3}, 32'h0F0);
    check_eq("depth1", {20'd0, rgb1_cap}, 32'hF00);

    stim(32'd10, 32'd10);
    run_pixel();
    check_eq("tie4", {20'd0, rgb4}, 32'hF00);
    check_eq("tie3", {20'd0, rgb3}, 32'hF00);

    stim(32'hFFFF_FFFB, 32'd10);
    run_pixel();
    check_eq("signed4", {20'd0, rgb4}, 32'hF00);

    clear_in(); de = 1'b1;
    run_pixel();
    check_eq("bg4", {20'd0, rgb4}, 32'h0A5);
    check_eq("bg1", {20'd0, rgb1_cap}, 32'h0A5);

    clear_in(); set4(0, 32'd0, 12'hFFF, 1'b1); ins1 = 1'b1; col1 = 12'hFFF;
    run_pixel();
    check_eq("blank4", {20'd0, rgb4}, 32'h0);
    check_eq("blank1", {20'd0, rgb1_cap}, 32'h0);

    h_pat = 8'b1011_0010;
    v_pat = 8'b0110_0111;
    for (int j = 0; j < 10; j++) begin
      clear_in();
      if (j < 8) begin
        hs = h_pat[j];
        vs = v_pat[j];
      end
      step();
      if (j >= 2) begin
        check_eq("hsync_dly", {31'd0, hs4}, {31'd0, h_pat[j-2]});
        check_eq("vsync_dly", {31'd0, vs4}, {31'd0, v_pat[j-2]});
      end
    end

    // Active mode is 1; changing cfg_mode without a pulse must not matter.
    mode = 1'b0;
    stim(32'd50, 32'd10);
    run_pixel();
    check_eq("shadow_hold", {20'd0, rgb4}, 32'h0F0);

    stim(32'd50, 32'd10);
    step();
    stim(32'd50, 32'd10); fs = 1'b1; mode = 1'b0;
    step();
    clear_in();
    step();
    check_eq("inflight_old", {20'd0, rgb4}, 32'h0F0);
    step();
    check_eq("inflight_new", {20'd0, rgb4}, 32'hF00);
    step(); step();

    // The previous pulse carried one overlap pixel, so that frame counts 1.
    clear_in(); fs = 1'b1;
    step();
    check_eq("stat_prev_valid", {31'd0, sv4}, 32'd1);
    check_eq("stat_prev_cnt", {12'd0, so4}, 32'd1);
    clear_in();
    step();
    check_eq("stat_valid_once", {31'd0, sv4}, 32'd0);

    for (int k = 0; k < 7; k++) begin
      stim(32'd50, 32'd10);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      stim(32'd50, 32'd10); de = 1'b0;
      step();
    end
    clear_in(); de = 1'b1; ins4 = 4'b0001;
    step();
    clear_in();
    step();
    check_eq("stat_no_early", {31'd0, sv4}, 32'd0);
    stim(32'd50, 32'd10); fs = 1'b1;
    step();
    check_eq("stat7_valid", {31'd0, sv4}, 32'd1);
    check_eq("stat7_cnt", {12'd0, so4}, 32'd7);
    check_eq("stat7_sat", {29'd0, soS}, 32'd7);
    clear_in();
    step();
    check_eq("stat7_pulse_end", {31'd0, sv4}, 32'd0);
    check_eq("stat7_hold", {12'd0, so4}, 32'd7);

    for (int k = 0; k < 9; k++) begin
      stim(32'd50, 32'd10);
      step();
    end
    clear_in(); fs = 1'b1;
    step();
    check_eq("stat10_cnt", {12'd0, so4}, 32'd10);
    check_eq("stat10_sat", {29'd0, soS}, 32'd7);
    check_eq("stat10_sat_valid", {31'd0, svS}, 32'd1);
    clear_in();
    step();

    stim(32'd50, 32'd10); hs = 1'b1; vs = 1'b1;
    step();
    stim(32'd50, 32'd10); fs = 1'b1; mode = 1'b1; bg = 12'h123; hs = 1'b1;
    rst = 1'b1;
    step();
    check_eq("rstmid_rgb", {20'd0, rgb4}, 32'h0);
    check_eq("rstmid_sync", {30'd0, hs4, vs4}, 32'h0);
    check_eq("rstmid_stat", {11'd0, sv4, so4}, 32'h0);
    rst = 1'b0;
    clear_in();
    step();
    check_eq("rstmid_flush", {20'd0, rgb4}, 32'h0);
    check_eq("rstmid_novalid", {31'd0, sv4}, 32'd0);
    step();
    check_eq("rstmid_flush2", {20'd0, rgb4}, 32'h0);
    check_eq("rstmid_novalid2", {31'd0, sv4}, 32'd0);

    clear_in(); de = 1'b1;
    run_pixel();
    check_eq("rst_fs_ignored_bg", {20'd0, rgb4}, 32'h008);
    stim(32'd50, 32'd10);
    run_pixel();
    check_eq("rst_fs_ignored_mode", {20'd0, rgb4}, 32'hF00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_depth_compositor.md
PIXEL_DEPTH_COMPOSITOR -- requirements
Module: pixel_depth_compositor

Interface
REQ-001 Parameter NUM_CH, default 4, number of fragment channels (1..16).
REQ-002 Parameter Z_W, default 32, signed depth width (Q16.16 from the triangle evaluators).
REQ-003 Parameter COLOR_W, default 12, RGB colour width, divisible by 3 (4:4:4 at default).
REQ-004 Parameter STAT_W, default 20, overlap-counter width.
REQ-005 clk_pix  in  1  pixel clock; the only clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_pix  in  1  reset, synchronous, active-high.
REQ-007 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-008 in_hsync, in_vsync, in_de  in  1 each  display timing for the current pixel.
REQ-009 frag_inside  in  NUM_CH  per-channel coverage flag; bit i belongs to channel i.
REQ-010 frag_z  in  NUM_CH*Z_W  per-channel signed depth; channel i at [i*Z_W +: Z_W].
REQ-011 frag_color  in  NUM_CH*COLOR_W  per-channel colour; channel i at [i*COLOR_W +: COLOR_W].
REQ-012 cfg_mode  in  1  resolve mode: 0 = priority, 1 = nearest depth.
REQ-013 cfg_bg_color  in  COLOR_W  background colour.
REQ-014 vga_hsync, vga_vsync  out  1 each  delayed timing signals.
REQ-015 vga_r, vga_g, vga_b  out  COLOR_W/3 each  resolved colour; r = MSB third, b = LSB third.
REQ-016 stat_overlap  out  STAT_W  overlap-pixel count of the previous frame.
REQ-017 stat_valid  out  1  one-cycle pulse when stat_overlap updates.

Function
REQ-018 Fixed latency LAT = clog2(NUM_CH)+1 cycles from any input to vga_*; no stalls, one pixel accepted per cycle.
REQ-019 Reduction SHALL be a binary tree of clog2(NUM_CH) registered levels plus one output register; NUM_CH not a power of two padded with inactive entries at high indices; NUM_CH=1 gives LAT=1.
REQ-020 Tree node (a = lower index, b = higher): only one inside -> it; neither -> inactive; both, mode 0 -> a; both, mode 1 -> b only if b.z < a.z (signed, strict), else a.
REQ-021 Equal depths SHALL resolve to the lower channel index.
REQ-022 Output colour: winner colour if winner inside, else pixel's captured background; forced to 0 when the pixel's de = 0.
REQ-023 in_hsync, in_vsync, in_de SHALL be delayed exactly LAT cycles, aligned with colour.
REQ-024 Shadow registers act_mode, act_bg SHALL load cfg_mode, cfg_bg_color on the frame_start cycle; pixels presented in that cycle and later use the new values; cfg changes between pulses have no effect.
REQ-025 act_mode and act_bg SHALL travel with each pixel through the pipeline; in-flight pixels keep their values.
REQ-026 Overlap pixel: in_de = 1 and at least two frag_inside bits set.
REQ-027 Counter increments by 1 per overlap pixel, saturates at 2^STAT_W-1.
REQ-028 On frame_start: stat_overlap <= counter (excluding the current pixel), stat_valid = 1 next cycle for one cycle, counter <= 1 if current pixel overlaps else 0.
REQ-029 X/Z on frag_z or frag_color of non-inside channels SHALL not affect outputs.

Reset
REQ-030 rst_pix sampled high: all pipeline registers cleared (coverage 0, timing 0), vga_* = 0, stat_overlap = 0, stat_valid = 0, counter = 0, act_mode = 0, act_bg = 12'h008 (COLOR_W=12).
REQ-031 Reset mid-frame SHALL discard in-flight pixels; outputs 0 until LAT cycles of valid input after release; no stat_valid until next frame_start.
REQ-032 frame_start coincident with rst_pix SHALL be ignored.

Verification
REQ-033 Priority: NUM_CH=4, mode 0, ch1 (z=50, F00) and ch3 (z=10, 0F0) inside, de=1 -> after 3 cycles rgb = F,0,0.
REQ-034 Depth: same stimulus, mode 1 latched at frame_start -> rgb = 0,F,0; ch1 and ch3 both z=10 -> F,0,0.
REQ-035 Background/blank: no channel inside, bg 0A5 -> 0,A,5; de=0 with ch0 inside -> 0,0,0; hsync/vsync pattern reproduced delayed 3 cycles.
REQ-036 Shadowing: cfg_mode toggled mid-frame -> no output change until next frame_start; pixels in flight at that pulse keep old mode.
REQ-037 Stats: 7 overlap pixels (plus 3 overlaps with de=0) then frame_start -> stat_overlap = 7, stat_valid high exactly 1 cycle; STAT_W=3 with 10 overlaps -> 7 (saturation).
REQ-038 Reset and width: rst_pix mid-frame -> all outputs 0 next cycle; NUM_CH=3 and NUM_CH=1 -> LAT = 3 and 1, REQ-033 checks pass with remapped channels.
